// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl
// Brings up a PS/2 mouse (Reset 0xFF -> ACK 0xFA, BAT 0xAA, ID 0x00, then
// Enable Data Reporting 0xF4 -> ACK 0xFA) and then assembles the streamed
// bytes into 3-byte movement packets.
//
// Ports:
//   clk_sys, rst          system clock, asynchronous active-high reset
//   start                 one-cycle pulse, (re)starts initialisation from any state
//   tx_req/tx_byte        request to the host-to-device transmitter, byte held stable
//   tx_done/tx_ack_err    transmitter finished; ack_err = device did not line-ACK
//   rx_vld/rx_byte/rx_err byte from the PS/2 receiver, err = parity/stop error
//   pkt_vld/pkt_data      packet strobe, {Y, X, status}
//   init_done/init_fail   high in STREAM / FAIL
//   is_mouse              device answered ID 0x00
//   retry_cnt             failed attempts in the current init sequence
//   state_dbg             encoded FSM state
//
// Handshake: tx_req rises when a SEND state is entered and stays high with
// tx_byte stable until the cycle after tx_done; tx_done is only honoured while
// tx_req is high. rx_vld/tx_done/pkt_vld are single-cycle strobes with no
// back-pressure.
module ps2_mouse_init_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 25_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned PKT_GAP_CYC = 1_000_000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        start,
  output logic        tx_req,
  output logic [7:0]  tx_byte,
  input  logic        tx_done,
  input  logic        tx_ack_err,
  input  logic        rx_vld,
  input  logic [7:0]  rx_byte,
  input  logic        rx_err,
  output logic        pkt_vld,
  output logic [23:0] pkt_data,
  output logic        init_done,
  output logic        is_mouse,
  output logic        init_fail,
  output logic [1:0]  retry_cnt,
  output logic [3:0]  state_dbg
);

  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_SEND_RST     = 4'd1;
  localparam logic [3:0] S_WAIT_ACK_RST = 4'd2;
  localparam logic [3:0] S_WAIT_BAT     = 4'd3;
  localparam logic [3:0] S_WAIT_ID      = 4'd4;
  localparam logic [3:0] S_SEND_EN      = 4'd5;
  localparam logic [3:0] S_WAIT_ACK_EN  = 4'd6;
  localparam logic [3:0] S_RETRY        = 4'd7;
  localparam logic [3:0] S_FAIL         = 4'd8;
  localparam logic [3:0] S_STREAM       = 4'd9;

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GAP_W = $clog2(PKT_GAP_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(PKT_GAP_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(PKT_GAP_CYC);
  localparam logic [1:0]       RETRY_LAST = 2'(MAX_RETRY - 1);

  logic [3:0]       state_q, state_d;
  logic [1:0]       retry_q, retry_d;
  logic             is_mouse_q, is_mouse_d;
  logic             tx_req_q, tx_req_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      asm_q, asm_d;
  logic [23:0]      pkt_data_q, pkt_data_d;
  logic             pkt_vld_q, pkt_vld_d;

  logic in_wait, timeout, gap_hit, tx_fin, rx_ok;

  assign in_wait = (state_q == S_WAIT_ACK_RST) || (state_q == S_WAIT_BAT) ||
                   (state_q == S_WAIT_ID) || (state_q == S_WAIT_ACK_EN);
  // The last idle cycle of the window is the one where the count reaches TIMEOUT_CYC-1.
  assign timeout = in_wait && !rx_vld && (to_cnt_q >= TO_LAST);
  assign gap_hit = (state_q == S_STREAM) && (idx_q != 2'd0) && !rx_vld && (gap_cnt_q >= GAP_LAST);
  // A tx_done while tx_req is low belongs to an aborted transfer and is ignored.
  assign tx_fin  = tx_req_q && tx_done;
  assign rx_ok   = rx_vld && !rx_err;

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    is_mouse_d = is_mouse_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    pkt_data_d = pkt_data_q;
    pkt_vld_d  = 1'b0;
    tx_byte_d  = tx_byte_q;

    if (start) begin
      state_d    = S_SEND_RST;
      retry_d    = 2'd0;
      is_mouse_d = 1'b0;
      idx_d      = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_SEND_RST, S_SEND_EN: begin
          if (tx_fin) begin
            if (tx_ack_err)                state_d = S_RETRY;
            else if (state_q == S_SEND_RST) state_d = S_WAIT_ACK_RST;
            else                           state_d = S_WAIT_ACK_EN;
          end
        end
        S_WAIT_ACK_RST: begin
          if (rx_vld)       state_d = (rx_ok && rx_byte == 8'hFA) ? S_WAIT_BAT : S_RETRY;
          else if (timeout) state_d = S_RETRY;
        end
        S_WAIT_BAT: begin
          if (rx_vld)       state_d = (rx_ok && rx_byte == 8'hAA) ? S_WAIT_ID : S_RETRY;
          else if (timeout) state_d = S_RETRY;
        end
        S_WAIT_ID: begin
          if (rx_vld) begin
            if (rx_err) begin
              state_d = S_RETRY;
            end else if (rx_byte == 8'h00) begin
              is_mouse_d = 1'b1;
              state_d    = S_SEND_EN;
            end else begin
              // A non-mouse device will not change its answer; retrying is pointless.
              is_mouse_d = 1'b0;
              state_d    = S_FAIL;
            end
          end else if (timeout) begin
            state_d = S_RETRY;
          end
        end
        S_WAIT_ACK_EN: begin
          if (rx_vld) begin
            state_d = (rx_ok && rx_byte == 8'hFA) ? S_STREAM : S_RETRY;
            idx_d   = 2'd0;
          end else if (timeout) begin
            state_d = S_RETRY;
          end
        end
        S_RETRY: begin
          if (retry_q == RETRY_LAST) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = S_SEND_RST;
          end
        end
        S_FAIL: ;
        S_STREAM: begin
          if (rx_vld) begin
            if (rx_err) begin
              idx_d = 2'd0;
            end else begin
              case (idx_q)
                2'd0: begin
                  // Status byte always has bit3 set; anything else is a misaligned byte.
                  if (rx_byte[3]) begin
                    asm_d[7:0] = rx_byte;
                    idx_d      = 2'd1;
                  end
                end
                2'd1: begin
                  asm_d[15:8] = rx_byte;
                  idx_d       = 2'd2;
                end
                2'd2: begin
                  pkt_data_d = {rx_byte, asm_q};
                  pkt_vld_d  = 1'b1;
                  idx_d      = 2'd0;
                end
                default: idx_d = 2'd0;
              endcase
            end
          end else if (gap_hit) begin
            idx_d = 2'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Request follows the SEND states; start forces one low cycle so the
    // transmitter sees the abort before the new Reset command.
    tx_req_d = !start && ((state_d == S_SEND_RST) || (state_d == S_SEND_EN));
    if (tx_req_d) tx_byte_d = (state_d == S_SEND_EN) ? 8'hF4 : 8'hFF;

    if (!in_wait || (state_d != state_q)) to_cnt_d = '0;
    else if (to_cnt_q != TO_MAX)          to_cnt_d = to_cnt_q + 1'b1;
    else                                  to_cnt_d = to_cnt_q;

    if ((state_q != S_STREAM) || (idx_q == 2'd0) || rx_vld || start) gap_cnt_d = '0;
    else if (gap_cnt_q != GAP_MAX) gap_cnt_d = gap_cnt_q + 1'b1;
    else                           gap_cnt_d = gap_cnt_q;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      retry_q    <= 2'd0;
      is_mouse_q <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_byte_q  <= 8'h00;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= 2'd0;
      asm_q      <= 16'h0;
      pkt_data_q <= 24'h0;
      pkt_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      is_mouse_q <= is_mouse_d;
      tx_req_q   <= tx_req_d;
      tx_byte_q  <= tx_byte_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      pkt_data_q <= pkt_data_d;
      pkt_vld_q  <= pkt_vld_d;
    end
  end

  assign tx_req    = tx_req_q;
  assign tx_byte   = tx_byte_q;
  assign pkt_vld   = pkt_vld_q;
  assign pkt_data  = pkt_data_q;
  assign init_done = (state_q == S_STREAM);
  assign init_fail = (state_q == S_FAIL);
  assign is_mouse  = is_mouse_q;
  assign retry_cnt = retry_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
module tb_ps2_mouse_init_ctrl;

  localparam int unsigned TO_CYC  = 100;
  localparam int unsigned GAP_CYC = 50;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        tx_req;
  logic [7:0]  tx_byte;
  logic        tx_done = 1'b0;
  logic        tx_ack_err = 1'b0;
  logic        rx_vld = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_err = 1'b0;
  logic        pkt_vld;
  logic [23:0] pkt_data;
  logic        init_done;
  logic        is_mouse;
  logic        init_fail;
  logic [1:0]  retry_cnt;
  logic [3:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  exp_tx_q[$];
  logic [23:0] exp_pkt_q[$];
  logic        tx_req_prev = 1'b0;

  ps2_mouse_init_ctrl #(
    .TIMEOUT_CYC(TO_CYC),
    .MAX_RETRY(3),
    .PKT_GAP_CYC(GAP_CYC)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .start(start),
    .tx_req(tx_req), .tx_byte(tx_byte), .tx_done(tx_done), .tx_ack_err(tx_ack_err),
    .rx_vld(rx_vld), .rx_byte(rx_byte), .rx_err(rx_err),
    .pkt_vld(pkt_vld), .pkt_data(pkt_data),
    .init_done(init_done), .is_mouse(is_mouse), .init_fail(init_fail),
    .retry_cnt(retry_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every tx_req rise and every pkt_vld pops one expectation
  always @(negedge clk_sys) begin
    if (rst) begin
      tx_req_prev = 1'b0;
    end else begin
      if (tx_req && !tx_req_prev) begin
        check("tx_unexpected", 32'(exp_tx_q.size() != 0), 32'd1);
        if (exp_tx_q.size() != 0) check("tx_byte", 32'(tx_byte), 32'(exp_tx_q.pop_front()));
      end
      tx_req_prev = tx_req;
      if (pkt_vld) begin
        check("pkt_unexpected", 32'(exp_pkt_q.size() != 0), 32'd1);
        if (exp_pkt_q.size() != 0) check("pkt_data", 32'(pkt_data), 32'(exp_pkt_q.pop_front()));
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic err);
    rx_vld  = 1'b1;
    rx_byte = b;
    rx_err  = err;
    tick();
    rx_vld  = 1'b0;
    rx_err  = 1'b0;
  endtask

  task automatic wait_tx_req();
    for (int i = 0; i < 20 && !tx_req; i++) tick();
    check("tx_req_wait", 32'(tx_req), 32'd1);
  endtask

  task automatic serve_tx(input logic err);
    wait_tx_req();
    tick();
    tx_done    = 1'b1;
    tx_ack_err = err;
    tick();
    tx_done    = 1'b0;
    tx_ack_err = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    check(tag, {28'h0, init_done, is_mouse, init_fail, 1'b0}, {28'h0, 4'b1100});
  endtask

  initial begin
    int n;

    // reset state
    repeat (3) tick();
    check("rst_tx", {23'h0, tx_req, tx_byte}, 32'h0);
    check("rst_pkt", {7'h0, pkt_vld, pkt_data}, 32'h0);
    check("rst_flags", {25'h0, init_done, is_mouse, init_fail, retry_cnt, 1'b0}, 32'h0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    tick();

    // clean bring-up
    exp_tx_q.push_back(8'hFF);
    pulse_start();
    serve_tx(1'b0);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    send_rx(8'h00, 1'b0);
    exp_tx_q.push_back(8'hF4);
    serve_tx(1'b0);
    send_rx(8'hFA, 1'b0);
    check_stream("clean_init_flags");
    check("clean_init_retry", 32'(retry_cnt), 32'd0);
    check("clean_init_state", 32'(state_dbg), 32'd9);

    // packet with a leading misaligned byte
    send_rx(8'h01, 1'b0);
    send_rx(8'h08, 1'b0);
    send_rx(8'h05, 1'b0);
    exp_pkt_q.push_back(24'hFB0508);
    send_rx(8'hFB, 1'b0);
    tick();

    // short gap keeps the packet
    send_rx(8'h09, 1'b0);
    repeat (10) tick();
    send_rx(8'h10, 1'b0);
    exp_pkt_q.push_back(24'h201009);
    send_rx(8'h20, 1'b0);
    tick();

    // long gap discards the partial packet
    send_rx(8'h09, 1'b0);
    send_rx(8'h10, 1'b0);
    repeat (GAP_CYC + 1) tick();
    send_rx(8'h18, 1'b0);
    send_rx(8'h01, 1'b0);
    exp_pkt_q.push_back(24'h020118);
    send_rx(8'h02, 1'b0);
    tick();
    check("gap_pkt_hold", 32'(pkt_data), 32'h020118);

    // rx_err discards the partial packet
    send_rx(8'h09, 1'b0);
    send_rx(8'h10, 1'b0);
    send_rx(8'h55, 1'b1);
    check("err_pkt_hold", 32'(pkt_data), 32'h020118);
    send_rx(8'h18, 1'b0);
    send_rx(8'h01, 1'b0);
    exp_pkt_q.push_back(24'h020118);
    send_rx(8'h02, 1'b0);
    tick();

    // reset mid-stream clears outputs immediately
    send_rx(8'h08, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_pkt", {7'h0, pkt_vld, pkt_data}, 32'h0);
    check("rst_mid_flags", {25'h0, init_done, is_mouse, init_fail, retry_cnt, 1'b0}, 32'h0);
    check("rst_mid_state", 32'(state_dbg), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // wrong BAT every attempt -> FAIL after three Reset commands
    pulse_start();
    for (int a = 0; a < 3; a++) begin
      exp_tx_q.push_back(8'hFF);
      serve_tx(1'b0);
      send_rx(8'hFA, 1'b0);
      send_rx(8'hFC, 1'b0);
    end
    repeat (10) tick();
    check("retry_fail_flags", {29'h0, init_done, init_fail, 1'b0}, 32'h2);
    check("retry_fail_cnt", 32'(retry_cnt), 32'd2);
    check("retry_fail_state", 32'(state_dbg), 32'd8);

    // line NACK retries; a non-mouse ID fails without retry
    exp_tx_q.push_back(8'hFF);
    pulse_start();
    check("restart_clears_fail", 32'(init_fail), 32'd0);
    serve_tx(1'b1);
    exp_tx_q.push_back(8'hFF);
    serve_tx(1'b0);
    check("nack_retry_cnt", 32'(retry_cnt), 32'd1);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    send_rx(8'h03, 1'b0);
    tick();
    check("bad_id_flags", {29'h0, is_mouse, init_fail, init_done}, 32'h2);
    check("bad_id_retry", 32'(retry_cnt), 32'd1);

    // silence after the Reset ACK times out after exactly TO_CYC cycles
    exp_tx_q.push_back(8'hFF);
    pulse_start();
    serve_tx(1'b0);
    exp_tx_q.push_back(8'hFF);
    n = 0;
    while (state_dbg != 4'd7 && n < 3 * TO_CYC) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO_CYC));
    serve_tx(1'b0);
    check("timeout_retry_cnt", 32'(retry_cnt), 32'd1);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    send_rx(8'h00, 1'b0);
    exp_tx_q.push_back(8'hF4);
    serve_tx(1'b0);
    send_rx(8'hFA, 1'b0);
    check_stream("timeout_then_init");
    check("timeout_then_retry", 32'(retry_cnt), 32'd1);

    // start while Enable is being requested
    exp_tx_q.push_back(8'hFF);
    pulse_start();
    serve_tx(1'b0);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    exp_tx_q.push_back(8'hF4);
    send_rx(8'h00, 1'b0);
    wait_tx_req();
    check("en_is_mouse", 32'(is_mouse), 32'd1);
    exp_tx_q.push_back(8'hFF);
    pulse_start();
    check("abort_tx_req_low", 32'(tx_req), 32'd0);
    check("abort_flags", {30'h0, init_done, is_mouse}, 32'h0);
    check("abort_state", 32'(state_dbg), 32'd1);
    tick();
    check("abort_tx_req_high", {23'h0, tx_req, tx_byte}, 32'h1FF);
    repeat (3) tick();

    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
    check("pkt_queue_drained", 32'(exp_pkt_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_init_ctrl.md
Name: ps2_mouse_init_ctrl

Overview:
- Sequences PS/2 mouse bring-up: sends Reset (0xFF), checks ACK (0xFA), BAT pass (0xAA) and device ID (0x00), then sends Enable Data Reporting (0xF4) and checks its ACK.
- Drives the host-to-device PS/2 transmitter through a request/done handshake and consumes the byte-level PS/2 receiver output.
- After initialisation, assembles received bytes into 3-byte movement packets for downstream logic.
- Handles timeouts, retries and packet resynchronisation.

Parameters:
- TIMEOUT_CYC, 25_000_000: clk_sys cycles allowed in any WAIT state before a timeout (500 ms at 50 MHz).
- MAX_RETRY, 3: number of failed init attempts before the block enters FAIL.
- PKT_GAP_CYC, 1_000_000: idle cycles between stream bytes after which a partial packet is discarded.

Ports:
- clk_sys  in  1  50 MHz system clock.
- rst  in  1  Reset. Asynchronous, active-high.
- start  in  1  One-cycle pulse that starts or restarts initialisation. Honoured in every state.
- tx_req  out  1  Transmit request. Held high until tx_done.
- tx_byte  out  8  Command byte. Stable while tx_req is high.
- tx_done  in  1  One-cycle pulse: transmitter finished the byte.
- tx_ack_err  in  1  Qualifies tx_done: the device did not line-ACK the byte.
- rx_vld  in  1  One-cycle pulse: rx_byte is valid.
- rx_byte  in  8  Received byte.
- rx_err  in  1  Qualifies rx_vld: parity or stop-bit error.
- pkt_vld  out  1  One-cycle pulse: pkt_data is valid.
- pkt_data  out  24  Packed packet: [7:0] status, [15:8] X, [23:16] Y.
- init_done  out  1  High in STREAM.
- is_mouse  out  1  Set when ID 0x00 is received.
- init_fail  out  1  High in FAIL.
- retry_cnt  out  2  Failed attempts in the current init sequence.
- state_dbg  out  4  Encoded FSM state.

Behaviour:
Reset:
- state = IDLE.
- All outputs are 0, including tx_byte = 0x00 and pkt_data = 0.

FSM states and transitions:
- IDLE: on start, go to SEND_RST. Clear retry_cnt, is_mouse and init_done.
- SEND_RST: tx_req = 1, tx_byte = 0xFF.
  - tx_done with tx_ack_err = 0: go to WAIT_ACK_RST.
  - tx_done with tx_ack_err = 1: go to RETRY.
- WAIT_ACK_RST: rx 0xFA goes to WAIT_BAT.
- WAIT_BAT: rx 0xAA goes to WAIT_ID.
- WAIT_ID: rx 0x00 sets is_mouse = 1 and goes to SEND_EN. Any other error-free ID sets is_mouse = 0 and goes to FAIL with no retry.
- SEND_EN: tx_byte = 0xF4. Same tx_done rules as SEND_RST; success goes to WAIT_ACK_EN.
- WAIT_ACK_EN: rx 0xFA goes to STREAM and sets init_done = 1.
- Rules for every WAIT state:
  - Any other byte, or rx_err, goes to RETRY.
  - The timeout counter clears on state entry. With no rx_vld for TIMEOUT_CYC cycles, go to RETRY.
- RETRY (one cycle):
  - If retry_cnt == MAX_RETRY-1, go to FAIL.
  - Otherwise increment retry_cnt and go to SEND_RST.
- FAIL: init_fail = 1. Stay until start.
- STREAM: packet assembly (below). Stay until start or rst.

start:
- Forces SEND_RST on the next cycle from any state.
- Clears retry_cnt, init_done, init_fail, is_mouse and byte_idx.
- Drops tx_req. The transmitter aborts and does not pulse tx_done afterwards.

Handshake and input gating:
- tx_req rises on entry to a SEND state and falls the cycle after tx_done.
- tx_done in any other state is ignored.
- rx_vld is ignored in IDLE, SEND_*, RETRY and FAIL.

STREAM packet assembly:
- byte_idx counts 0..2.
- At byte_idx 0, a byte with bit3 = 0 is discarded (sync loss) and byte_idx stays 0.
- byte_idx 0, 1, 2 write pkt_data[7:0], [15:8], [23:16] respectively.
- On the third byte, pkt_vld pulses on the following cycle and byte_idx wraps to 0.
- rx_err, or PKT_GAP_CYC cycles with no rx_vld while byte_idx != 0, clears byte_idx. pkt_data holds its previous value.
- rx_vld on the same cycle as start: start wins and the byte is dropped.

Counters:
- Timeout and gap counters are width $clog2(max+1) and saturate; they do not wrap.
- retry_cnt never exceeds MAX_RETRY-1.

Test Plan:
- TIMEOUT_CYC=100. start; ack both tx_done cleanly; feed FA, AA, 00, then FA -> tx_byte sequence FF then F4, is_mouse=1, init_done=1, retry_cnt=0.
- Feed FA then FC at BAT each attempt, MAX_RETRY=3 -> exactly 3 FF transmissions, retry_cnt=2, init_fail=1, init_done=0.
- No response after the FF ACK for 100 cycles -> RETRY, second FF sent, retry_cnt=1; a clean sequence then yields init_done=1.
- In STREAM, feed 0x08, 0x05, 0xFB -> one pkt_vld with pkt_data=0xFB0508. Preceding byte 0x01 is discarded (bit3=0) and does not shift alignment.
- In STREAM, feed 0x09, 0x10, then a gap of PKT_GAP_CYC+1 cycles, then 0x18, 0x01, 0x02 -> only pkt_data=0x020118 emitted. The same holds when the gap is replaced by a byte with rx_err=1.
- Assert start mid-SEND_EN while tx_req=1 -> tx_req drops for one cycle then re-asserts with tx_byte=FF; init_done and is_mouse clear. rst mid-STREAM -> all outputs 0 immediately.
